// File: rtl/ovl_win_unchange_mc_pkg.sv
// ovl_win_pkg: shared state type and popcount helper for the multi-channel window-unchange checker.
package ovl_win_pkg;
    typedef enum logic {IDLE, WIN} win_state_e;
    localparam int MAX_CHANNELS = 64;
    function automatic int unsigned popcount(input logic [MAX_CHANNELS-1:0] v);
        popcount = 0;
        for (int i = 0; i < MAX_CHANNELS; i++) popcount += {31'd0, v[i]};
    endfunction
endpackage

// File: rtl/ovl_win_unchange_mc_if.sv
// ovl_win_unchange_mc_if: observed-DUT inputs and checker outputs of the window-unchange checker.
interface ovl_win_unchange_mc_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 4,
    parameter int COUNT_W  = 8
);
    logic                      enable;
    logic [CHANNELS-1:0]       start_event;
    logic [CHANNELS-1:0]       end_event;
    logic [CHANNELS*WIDTH-1:0] test_expr;
    logic [CHANNELS-1:0]       fire;
    logic [CHANNELS-1:0]       fire_timeout;
    logic [CHANNELS-1:0]       win_open;
    logic [COUNT_W-1:0]        viol_count;
    modport master (output enable, start_event, end_event, test_expr,
                    input fire, fire_timeout, win_open, viol_count);
    modport slave (input enable, start_event, end_event, test_expr,
                   output fire, fire_timeout, win_open, viol_count);
endinterface

// File: rtl/ovl_win_unchange_chan.sv
// ovl_win_unchange_chan: one channel's IDLE/WIN FSM, reference register and unchange compare.
// The window timer exists only when OVL_WIN_TIMEOUT_EN is defined.
module ovl_win_unchange_chan
    import ovl_win_pkg::*;
#(
    parameter int WIDTH = 4
`ifdef OVL_WIN_TIMEOUT_EN
  , parameter int WINDOW_MAX = 16
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_event,
    input  logic             end_event,
    input  logic [WIDTH-1:0] test_expr,
    output logic             win_open,
    output logic             fire_next,
    output logic             fire_timeout_next
);
    win_state_e       state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    assign win_open = state_q == WIN;
    always_comb begin
        fire_next = state_q == WIN && test_expr != ref_q;
        ref_d     = (state_q == WIN || (start_event && !end_event)) ? test_expr : ref_q;
        state_d   = state_q == IDLE ? (start_event && !end_event ? WIN : IDLE)
                                    : (end_event || fire_timeout_next ? IDLE : WIN);
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ref_q   <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
        end
    end
`ifdef OVL_WIN_TIMEOUT_EN
    localparam int TW = $clog2(WINDOW_MAX + 1);
    logic [TW-1:0] timer_q, timer_d;
    // end on the same edge the limit is reached closes the window normally
    always_comb begin
        timer_d           = state_q == WIN ? timer_q + 1'b1 : '0;
        fire_timeout_next = state_q == WIN && !end_event && timer_d == TW'(WINDOW_MAX);
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) timer_q <= '0;
        else        timer_q <= timer_d;
    end
`else
    assign fire_timeout_next = 1'b0;
`endif
endmodule

// File: rtl/ovl_win_unchange_mc.sv
// ovl_win_unchange_mc: multi-channel window-unchange checker with saturating violation count.
// Define OVL_WIN_TIMEOUT_EN to build the per-channel WINDOW_MAX timeout check.
module ovl_win_unchange_mc
    import ovl_win_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 4,
    parameter int COUNT_W    = 8,
    parameter int WINDOW_MAX = 16
) (
    input logic             clock,
    input logic             reset,
    ovl_win_unchange_mc_if.slave chk
);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS || WIDTH < 1 || COUNT_W < 1 || COUNT_W > 30 || WINDOW_MAX < 1) begin : g_bad_params
        $error("ovl_win_unchange_mc: parameter out of range");
    end
    logic [CHANNELS-1:0] fire_next, fire_timeout_next, win_open;
    logic [CHANNELS-1:0] fire_d, fire_q, fire_timeout_d, fire_timeout_q;
    logic [COUNT_W-1:0]  viol_count_d, viol_count_q;
    logic [31:0]         sum;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        ovl_win_unchange_chan #(
            .WIDTH(WIDTH)
`ifdef OVL_WIN_TIMEOUT_EN
          , .WINDOW_MAX(WINDOW_MAX)
`endif
        ) u_chan (
            .clock            (clock),
            .reset            (reset),
            .start_event      (chk.start_event[i]),
            .end_event        (chk.end_event[i]),
            .test_expr        (chk.test_expr[i*WIDTH +: WIDTH]),
            .win_open         (win_open[i]),
            .fire_next        (fire_next[i]),
            .fire_timeout_next(fire_timeout_next[i])
        );
    end
    // a channel that both violates and times out on one edge counts once
    always_comb begin
        fire_d         = fire_next & {CHANNELS{chk.enable}};
        fire_timeout_d = fire_timeout_next & {CHANNELS{chk.enable}};
        sum            = 32'(viol_count_q) + popcount(MAX_CHANNELS'(fire_d | fire_timeout_d));
        viol_count_d   = sum > 32'(CNT_MAX) ? CNT_MAX : sum[COUNT_W-1:0];
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fire_q         <= '0;
            fire_timeout_q <= '0;
            viol_count_q   <= '0;
        end else begin
            fire_q         <= fire_d;
            fire_timeout_q <= fire_timeout_d;
            viol_count_q   <= viol_count_d;
        end
    end
    assign chk.fire         = fire_q;
    assign chk.fire_timeout = fire_timeout_q;
    assign chk.win_open     = win_open;
    assign chk.viol_count   = viol_count_q;
endmodule
